alu16_arbiter: RTL and testbench
================================

Name: alu16_arbiter

Overview:
- Shares the single 16-bit ALU (and/or/add/slt/sub, 3-bit op) between two requesters, e.g. the main execute stage and the address/branch unit.
- Accepts requests over a valid/ready handshake and arbitrates round-robin.
- Drives the ALU operands from registers, captures the result and zero flag, and returns a per-requester response with valid/ready.
- Sits between the requesters and the combinational ALU instance; the ALU itself is not modified.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- OPW, 3, op code width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req0_op  in  OPW  0=and 1=or 2=add 3=slt(a>b) 4=sub(b-a)
- rsp0_valid  out  1  result available for requester 0
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_r  out  WIDTH  result
- rsp0_zero  out  1  result==0
- req1_*, rsp1_*: identical set for requester 1
- alu_a  out  WIDTH  registered operand to ALU in_a
- alu_b  out  WIDTH  registered operand to ALU in_b
- alu_op  out  OPW  registered op to ALU
- alu_r  in  WIDTH  ALU result
- alu_zero  in  1  ALU isZero
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low) puts every output to 0: state=IDLE, alu_a/alu_b/alu_op=0, rsp*_valid=0, rsp*_r=0, rsp*_zero=0, req*_ready=0, busy=0. The last-served pointer resets to 1, so requester 0 wins the first tie.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - req*_ready is combinational and asserted only to the winner.
  - Only one valid: that requester wins.
  - Both valid: the requester not last served wins.
  - On handshake (valid&ready, cycle T): latch a/b/op into alu_a/alu_b/alu_op, record the winner as owner, go to EXEC.
- EXEC (T+1):
  - The ALU settles combinationally.
  - At the clock edge, capture into the owner's rsp_r/rsp_zero.
  - Op 5-7 is illegal: capture r=0, zero=1, ignoring alu_r.
  - Go to RESP.
- RESP (from T+2):
  - Owner's rsp_valid=1.
  - rsp_r/rsp_zero stay stable while valid.
  - When rsp_ready=1: clear rsp_valid, set last-served=owner, go to IDLE.
- Latency: accept at T -> rsp_valid at T+2 minimum. Throughput without the optional feature is one op per 3 cycles.
- No new request is accepted outside IDLE. A requester holds valid/operands until its ready pulse.
- Non-owner rsp_valid is always 0. Non-owner rsp_r/rsp_zero keep their last captured values.
- Arithmetic follows the ALU: add and sub wrap modulo 2^WIDTH; slt is unsigned a>b giving 1/0.
- Reset mid-operation (any state) aborts immediately to reset values. The in-flight result is lost and no response is produced.
- A requester dropping valid before ready is a protocol violation; behaviour is undefined.

Optional Feature:
- Macro ALU16_ARB_BACK2BACK_EN.
- Defined:
  - In RESP, when rsp_ready=1 and any req*_valid is asserted, arbitrate in the same cycle (round-robin using the updated last-served).
  - Assert the winner's req_ready, latch operands and go directly to EXEC.
  - Sustained throughput becomes one op per 2 cycles.
- Undefined: RESP always returns to IDLE first, as described above.

Test Plan:
- Single op: req0 a=0x0003 b=0x0005 op=2 -> req0_ready at T, rsp0_valid at T+2, rsp0_r=0x0008, rsp0_zero=0.
- Sub/zero flag: req1 a=0x1234 b=0x1234 op=4 -> rsp1_r=0x0000, rsp1_zero=1. Then a=1 b=0 op=4 -> rsp1_r=0xFFFF.
- Tie then fairness: both valid from reset, req0 op=0 and req1 op=1 held continuously -> grant order 0,1,0,1. rsp*_valid never asserted for the non-owner.
- Backpressure: rsp0_ready held low 5 cycles -> rsp0_valid and rsp0_r stable, no new grant. Requester 1 waits with req1_ready=0.
- Illegal op 6 with a=0x00FF b=0x0F0F -> rsp_r=0x0000, rsp_zero=1. Also slt a=0x8000 b=0x0001 -> r=0x0001.
- Reset in EXEC: rst_n low mid-op -> all outputs 0 immediately, no rsp_valid after release. The next tie is won by requester 0.

Source files
------------

// File: rtl/alu16_arbiter.sv
// alu16_arbiter: shares one combinational 16-bit ALU between two requesters.
// Requests arrive over valid/ready. Arbitration is round-robin. Operands are
// registered toward the ALU. The result is captured into the owner's response
// register and held until that requester consumes it.
// Optional macro ALU16_ARB_BACK2BACK_EN: when the response is consumed in
// RESP, a pending request is granted in the same cycle. This allows one op
// every 2 cycles.
module alu16_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_r,
    output logic             rsp0_zero,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_r,
    output logic             rsp1_zero,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_zero,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Highest legal op code (sub). Anything above is treated as illegal.
    localparam logic [OPW-1:0] OP_MAX = OPW'(4);

    state_t           state_reg;
    logic             owner_reg;
    logic             last_reg;
    logic [WIDTH-1:0] alu_a_reg;
    logic [WIDTH-1:0] alu_b_reg;
    logic [OPW-1:0]   alu_op_reg;
    logic [1:0]       rsp_valid_reg;
    logic [WIDTH-1:0] rsp_r_reg [2];
    logic [1:0]       rsp_zero_reg;

    // Per-requester views of the flat ports, so the two lanes can be indexed.
    logic [1:0]       req_valid_w;
    logic [1:0]       rsp_ready_w;
    logic [WIDTH-1:0] req_a_w [2];
    logic [WIDTH-1:0] req_b_w [2];
    logic [OPW-1:0]   req_op_w [2];

    assign req_valid_w = {req1_valid, req0_valid};
    assign rsp_ready_w = {rsp1_ready, rsp0_ready};
    assign req_a_w[0]  = req0_a;
    assign req_a_w[1]  = req1_a;
    assign req_b_w[0]  = req0_b;
    assign req_b_w[1]  = req1_b;
    assign req_op_w[0] = req0_op;
    assign req_op_w[1] = req1_op;

    logic       rsp_hs_w;
    logic       arb_open_w;
    logic       arb_last_w;
    logic [1:0] grant_w;
    logic       accept_w;
    logic       winner_w;
    logic       op_legal_w;

    // The owner consumes its response this cycle.
    assign rsp_hs_w = (state_reg == RESP) && rsp_ready_w[owner_reg];

    // Arbitration window. Ready is gated by rst_n so that nothing is offered
    // while reset is held.
`ifdef ALU16_ARB_BACK2BACK_EN
    assign arb_open_w = rst_n && ((state_reg == IDLE) || rsp_hs_w);
`else
    assign arb_open_w = rst_n && (state_reg == IDLE);
`endif

    // Back-to-back grants use the owner that is just being retired as the
    // last-served value.
    assign arb_last_w = rsp_hs_w ? owner_reg : last_reg;

    // A lane wins if it is the only one valid, or if it was not served last.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            assign grant_w[gi] = arb_open_w && req_valid_w[gi] &&
                                 (!req_valid_w[1-gi] || (arb_last_w != 1'(gi)));
        end
    endgenerate

    assign accept_w   = |grant_w;
    assign winner_w   = grant_w[1];
    assign op_legal_w = (alu_op_reg <= OP_MAX);

    assign req0_ready = grant_w[0];
    assign req1_ready = grant_w[1];
    assign rsp0_valid = rsp_valid_reg[0];
    assign rsp1_valid = rsp_valid_reg[1];
    assign rsp0_r     = rsp_r_reg[0];
    assign rsp1_r     = rsp_r_reg[1];
    assign rsp0_zero  = rsp_zero_reg[0];
    assign rsp1_zero  = rsp_zero_reg[1];
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_op     = alu_op_reg;
    assign busy       = (state_reg != IDLE);

    // Control FSM: grant and latch operands, capture the ALU result, then hold
    // the response until it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            last_reg      <= 1'b1;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_op_reg    <= '0;
            rsp_valid_reg <= '0;
            rsp_r_reg[0]  <= '0;
            rsp_r_reg[1]  <= '0;
            rsp_zero_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept_w) begin
                        alu_a_reg  <= req_a_w[winner_w];
                        alu_b_reg  <= req_b_w[winner_w];
                        alu_op_reg <= req_op_w[winner_w];
                        owner_reg  <= winner_w;
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    // Illegal ops report a zero result, whatever the ALU drives.
                    rsp_r_reg[owner_reg]     <= op_legal_w ? alu_r : '0;
                    rsp_zero_reg[owner_reg]  <= op_legal_w ? alu_zero : 1'b1;
                    rsp_valid_reg[owner_reg] <= 1'b1;
                    state_reg                <= RESP;
                end
                RESP: begin
                    if (rsp_hs_w) begin
                        rsp_valid_reg[owner_reg] <= 1'b0;
                        last_reg                 <= owner_reg;
                        if (accept_w) begin
                            alu_a_reg  <= req_a_w[winner_w];
                            alu_b_reg  <= req_b_w[winner_w];
                            alu_op_reg <= req_op_w[winner_w];
                            owner_reg  <= winner_w;
                            state_reg  <= EXEC;
                        end else begin
                            state_reg  <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu16_arbiter.sv
// Directed testbench for alu16_arbiter (default build). A behavioural ALU is
// attached to the alu_* port group. Illegal op codes make it drive a nonzero
// pattern, so a design that fails to ignore alu_r is detected.
module tb_alu16_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
    logic [15:0] req0_a, req0_b, rsp0_r;
    logic [2:0]  req0_op;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [15:0] req1_a, req1_b, rsp1_r;
    logic [2:0]  req1_op;
    logic [15:0] alu_a, alu_b, alu_r;
    logic [2:0]  alu_op;
    logic        alu_zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu16_arbiter #(.WIDTH(16), .OPW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_r(rsp0_r), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_r(rsp1_r), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_r(alu_r), .alu_zero(alu_zero),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU: and/or/add/slt(a>b)/sub(b-a).
    always_comb begin
        alu_r = 16'hDEAD;
        case (alu_op)
            3'd0: alu_r = alu_a & alu_b;
            3'd1: alu_r = alu_a | alu_b;
            3'd2: alu_r = alu_a + alu_b;
            3'd3: alu_r = (alu_a > alu_b) ? 16'd1 : 16'd0;
            3'd4: alu_r = alu_b - alu_a;
            default: alu_r = 16'hDEAD;
        endcase
    end
    assign alu_zero = (alu_r == 16'd0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int who, input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic [2:0] op);
        if (who == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
        end
    endtask

    // One uncontended operation: accept at T, rsp_valid at T+2, then consume.
    task automatic run_op(input int who, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input logic [15:0] er,
                          input logic ez, input string tag);
        set_req(who, 1'b1, a, b, op);
        #1;
        chk({tag, "_ready"}, (who == 0) ? req0_ready : req1_ready, 1);
        cyc();
        set_req(who, 1'b0, 16'h0, 16'h0, 3'd0);
        chk({tag, "_busy_exec"}, busy, 1);
        chk({tag, "_alu_a"}, alu_a, a);
        chk({tag, "_alu_op"}, alu_op, op);
        chk({tag, "_valid_t1"}, (who == 0) ? rsp0_valid : rsp1_valid, 0);
        cyc();
        chk({tag, "_valid_t2"}, (who == 0) ? rsp0_valid : rsp1_valid, 1);
        chk({tag, "_other_valid"}, (who == 0) ? rsp1_valid : rsp0_valid, 0);
        chk({tag, "_r"}, (who == 0) ? rsp0_r : rsp1_r, er);
        chk({tag, "_zero"}, (who == 0) ? rsp0_zero : rsp1_zero, ez);
        if (who == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk({tag, "_valid_done"}, (who == 0) ? rsp0_valid : rsp1_valid, 0);
        chk({tag, "_busy_done"}, busy, 0);
        $display("op %s: who=%0d a=%h b=%h op=%0d r=%h", tag, who, a, b, op,
                 (who == 0) ? rsp0_r : rsp1_r);
    endtask

    initial begin
        rst_n = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        set_req(0, 1'b0, 16'h0, 16'h0, 3'd0);
        set_req(1, 1'b0, 16'h0, 16'h0, 3'd0);
        #1;
        // Reset state, including ready held low while in reset.
        req0_valid = 1'b1;
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_r", rsp1_r, 0);
        req0_valid = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single add, then sub with zero flag and wraparound.
        run_op(0, 16'h0003, 16'h0005, 3'd2, 16'h0008, 1'b0, "add");
        run_op(1, 16'h1234, 16'h1234, 3'd4, 16'h0000, 1'b1, "sub_zero");
        run_op(1, 16'h0001, 16'h0000, 3'd4, 16'hFFFF, 1'b0, "sub_wrap");
        // Illegal op ignores the ALU result. Unsigned slt.
        run_op(0, 16'h00FF, 16'h0F0F, 3'd6, 16'h0000, 1'b1, "illegal");
        run_op(0, 16'h8000, 16'h0001, 3'd3, 16'h0001, 1'b0, "slt");

        // Backpressure: req0 owns, rsp0_ready low, req1 waiting.
        set_req(0, 1'b1, 16'h00F0, 16'h0FF0, 3'd1);
        #1;
        chk("bp_ready0", req0_ready, 1);
        cyc();
        set_req(0, 1'b0, 16'h0, 16'h0, 3'd0);
        set_req(1, 1'b1, 16'h0007, 16'h0002, 3'd4);
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid0", rsp0_valid, 1);
            chk("bp_r0", rsp0_r, 16'h0FF0);
            chk("bp_ready1", req1_ready, 0);
            chk("bp_alu_a", alu_a, 16'h00F0);
            chk("bp_valid1", rsp1_valid, 0);
            $display("bp cycle %0d: rsp0_valid=%b rsp0_r=%h req1_ready=%b", k, rsp0_valid, rsp0_r, req1_ready);
            cyc();
        end
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        chk("bp_release_ready1", req1_ready, 1);
        cyc();
        set_req(1, 1'b0, 16'h0, 16'h0, 3'd0);
        cyc();
        chk("bp_valid1_late", rsp1_valid, 1);
        chk("bp_r1", rsp1_r, 16'hFFFB);
        chk("bp_r0_kept", rsp0_r, 16'h0FF0);
        rsp1_ready = 1'b1;
        cyc();
        rsp1_ready = 1'b0;

        // Reset while in EXEC.
        set_req(0, 1'b1, 16'h0001, 16'h0001, 3'd2);
        cyc();
        set_req(0, 1'b0, 16'h0, 16'h0, 3'd0);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_op", alu_op, 0);
        chk("mid_rst_rsp0_r", rsp0_r, 0);
        chk("mid_rst_rsp1_r", rsp1_r, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("mid_no_rsp0", rsp0_valid, 0);
        chk("mid_no_busy", busy, 0);
        $display("reset in EXEC: busy=%b rsp0_valid=%b", busy, rsp0_valid);

        // Tie from reset, both held: grants alternate 0,1,0,1.
        set_req(0, 1'b1, 16'h0F0F, 16'h00FF, 3'd0);
        set_req(1, 1'b1, 16'hF000, 16'h000F, 3'd1);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
            chk("rr_ready1", req1_ready, (k % 2 == 1) ? 1 : 0);
            cyc();
            chk("rr_exec_v0", rsp0_valid, 0);
            chk("rr_exec_v1", rsp1_valid, 0);
            cyc();
            chk("rr_v0", rsp0_valid, (k % 2 == 0) ? 1 : 0);
            chk("rr_v1", rsp1_valid, (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 0) chk("rr_r0", rsp0_r, 16'h000F);
            else            chk("rr_r1", rsp1_r, 16'hF00F);
            $display("rr grant %0d: rsp0_valid=%b rsp1_valid=%b", k, rsp0_valid, rsp1_valid);
            if (k % 2 == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
            cyc();
            rsp0_ready = 1'b0;
            rsp1_ready = 1'b0;
        end
        set_req(0, 1'b0, 16'h0, 16'h0, 3'd0);
        set_req(1, 1'b0, 16'h0, 16'h0, 3'd0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
